// File: rtl/ahb_lite_master_if.sv
// Command/response stream plus AHB-Lite bus bundle for ahb_lite_master.
// The master modport is the initiator's view; slave is the command source and AHB slave side.
interface ahb_lite_master_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0]        cmd_size;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              busy;
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [1:0]        hsize;
    logic              hwrite;
    logic [2:0]        hburst;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  hrdata, hready, hresp,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
        output hsel, haddr, htrans, hsize, hwrite, hburst, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output hrdata, hready, hresp,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
        input  hsel, haddr, htrans, hsize, hwrite, hburst, hwdata
    );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: valid/ready commands in, pipelined address/data phases out, one response each.
// Optional wait-state watchdog enabled by defining AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    ahb_lite_master_if.master bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic              a_vld_q, a_vld_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic              a_write_q, a_write_d;
    logic [1:0]        a_size_q, a_size_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;

    logic              d_vld_q, d_vld_d;
    logic              d_write_q, d_write_d;
    logic [1:0]        d_size_q, d_size_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;

    logic              cancel_q, cancel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic cmd_ready;
    logic cmd_accept;
    logic a_issue;
    logic d_done;
    logic err_first;
    logic tmo_fire;
    logic flush_rsp;

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

    function automatic logic [DATA_W-1:0] mask_rdata(input logic [DATA_W-1:0] data,
                                                     input logic [1:0]        size);
        logic [DATA_W-1:0] m;
        case (size)
            2'd0:    m = DATA_W'(8'hFF);
            2'd1:    m = DATA_W'(16'hFFFF);
            default: m = '1;
        endcase
        return data & m;
    endfunction

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             flush_q, flush_d;

    // A stalled data phase is abandoned on its TIMEOUT_CYCLES-th wait cycle.
    always_comb begin
        tmo_fire  = d_vld_q && !bus.hready && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d = '0;
        if (d_vld_q && !bus.hready && !tmo_fire) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        flush_d   = tmo_fire && a_vld_q;
        flush_rsp = flush_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            flush_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            flush_q   <= flush_d;
        end
    end
`else
    // Without the watchdog the limit never applies and the abandon path folds away.
    assign tmo_fire  = (TIMEOUT_CYCLES < 0);
    assign flush_rsp = 1'b0;
`endif

    // Next-state logic for the address (A) and data (D) holding stages.
    always_comb begin
        cmd_ready  = !a_vld_q || (bus.hready && !bus.hresp && !cancel_q);
        cmd_accept = bus.cmd_valid && cmd_ready;
        a_issue    = a_vld_q && !cancel_q && bus.hready;
        d_done     = d_vld_q && bus.hready;
        err_first  = d_vld_q && bus.hresp && !bus.hready;

        a_vld_d   = a_vld_q;
        a_addr_d  = a_addr_q;
        a_write_d = a_write_q;
        a_size_d  = a_size_q;
        a_wdata_d = a_wdata_q;
        if (tmo_fire || a_issue) begin
            a_vld_d = 1'b0;
        end
        if (cmd_accept) begin
            a_vld_d   = 1'b1;
            a_addr_d  = bus.cmd_addr;
            a_write_d = bus.cmd_write;
            a_size_d  = norm_size(bus.cmd_size);
            a_wdata_d = bus.cmd_wdata;
        end

        d_vld_d   = d_vld_q;
        d_write_d = d_write_q;
        d_size_d  = d_size_q;
        d_wdata_d = d_wdata_q;
        if (tmo_fire) begin
            d_vld_d = 1'b0;
        end else if (bus.hready) begin
            d_vld_d = a_issue;
            if (a_issue) begin
                d_write_d = a_write_q;
                d_size_d  = a_size_q;
                d_wdata_d = a_wdata_q;
            end
        end

        // Cancel covers the second ERROR cycle so the queued address phase is held back.
        cancel_d = !tmo_fire && (err_first || (cancel_q && !bus.hready));

        rsp_valid_d = d_done || tmo_fire || flush_rsp;
        rsp_error_d = (d_done && bus.hresp) || tmo_fire || flush_rsp;
        rsp_rdata_d = (d_done && !d_write_q) ? mask_rdata(bus.hrdata, d_size_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q     <= 1'b0;
            a_addr_q    <= '0;
            a_write_q   <= 1'b0;
            a_size_q    <= 2'd0;
            a_wdata_q   <= '0;
            d_vld_q     <= 1'b0;
            d_write_q   <= 1'b0;
            d_size_q    <= 2'd0;
            d_wdata_q   <= '0;
            cancel_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_vld_q     <= a_vld_d;
            a_addr_q    <= a_addr_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            d_vld_q     <= d_vld_d;
            d_write_q   <= d_write_d;
            d_size_q    <= d_size_d;
            d_wdata_q   <= d_wdata_d;
            cancel_q    <= cancel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Bus and response outputs come straight from the holding registers.
    assign bus.cmd_ready = cmd_ready;
    assign bus.hsel      = a_vld_q;
    assign bus.htrans    = (a_vld_q && !cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.haddr     = a_addr_q;
    assign bus.hsize     = a_size_q;
    assign bus.hwrite    = a_write_q;
    assign bus.hburst    = 3'b000;
    assign bus.hwdata    = d_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = a_vld_q || d_vld_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: cycle-exact stimulus with hand-computed expectations.
module tb_ahb_lite_master;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    ahb_lite_master_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    ahb_lite_master #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [6:0] a, input logic [1:0] s,
                             input logic [31:0] wd);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = s;
        bus.cmd_wdata = wd;
    endtask

    task automatic drive_idle();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic slave(input logic rdy, input logic rsp, input logic [31:0] rd);
        bus.hready = rdy;
        bus.hresp  = rsp;
        bus.hrdata = rd;
    endtask

    task automatic single_read(input string tag, input logic [6:0] a, input logic [1:0] s,
                               input logic [31:0] rd, input logic [31:0] exp_rd,
                               input logic [1:0] exp_sz);
        cyc(); drive_cmd(1'b0, a, s, 32'h0); #1;
        cyc(); drive_idle(); #1;
        chk_eq({tag, "_haddr"},  32'(bus.haddr),  32'(a));
        chk_eq({tag, "_hsize"},  32'(bus.hsize),  32'(exp_sz));
        chk_eq({tag, "_htrans"}, 32'(bus.htrans), 32'd2);
        cyc(); slave(1'b1, 1'b0, rd); #1;
        cyc(); slave(1'b1, 1'b0, 32'h0); #1;
        chk_eq({tag, "_rvalid"}, 32'(bus.rsp_valid), 32'd1);
        chk_eq({tag, "_rdata"},  bus.rsp_rdata,      exp_rd);
        chk_eq({tag, "_err"},    32'(bus.rsp_error), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_hsel"},   32'(bus.hsel),      32'd0);
        chk_eq({tag, "_htrans"}, 32'(bus.htrans),    32'd0);
        chk_eq({tag, "_haddr"},  32'(bus.haddr),     32'd0);
        chk_eq({tag, "_hsize"},  32'(bus.hsize),     32'd0);
        chk_eq({tag, "_hwrite"}, 32'(bus.hwrite),    32'd0);
        chk_eq({tag, "_hburst"}, 32'(bus.hburst),    32'd0);
        chk_eq({tag, "_hwdata"}, bus.hwdata,         32'd0);
        chk_eq({tag, "_rvalid"}, 32'(bus.rsp_valid), 32'd0);
        chk_eq({tag, "_rdata"},  bus.rsp_rdata,      32'd0);
        chk_eq({tag, "_rerr"},   32'(bus.rsp_error), 32'd0);
        chk_eq({tag, "_busy"},   32'(bus.busy),      32'd0);
        chk_eq({tag, "_crdy"},   32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_size  = 2'd0;
        bus.cmd_wdata = '0;
        slave(1'b1, 1'b0, 32'h0);

        repeat (3) cyc();
        chk_reset_outputs("rst");
        rst = 1'b0;

        // single word write: address phase N+1, data phase N+2, response N+3
        cyc(); drive_cmd(1'b1, 7'd0, 2'd2, 32'hA1B2C3D4); #1;
        chk_eq("wr_crdy", 32'(bus.cmd_ready), 32'd1);
        cyc(); drive_idle(); #1;
        chk_eq("wr_htrans", 32'(bus.htrans), 32'd2);
        chk_eq("wr_hsel",   32'(bus.hsel),   32'd1);
        chk_eq("wr_haddr",  32'(bus.haddr),  32'd0);
        chk_eq("wr_hwrite", 32'(bus.hwrite), 32'd1);
        chk_eq("wr_hsize",  32'(bus.hsize),  32'd2);
        cyc(); #1;
        chk_eq("wr_hwdata", bus.hwdata,          32'hA1B2C3D4);
        chk_eq("wr_idle",   32'(bus.htrans),     32'd0);
        chk_eq("wr_early",  32'(bus.rsp_valid),  32'd0);
        chk_eq("wr_busy",   32'(bus.busy),       32'd1);
        cyc(); #1;
        chk_eq("wr_rvalid", 32'(bus.rsp_valid), 32'd1);
        chk_eq("wr_rerr",   32'(bus.rsp_error), 32'd0);
        chk_eq("wr_rdata",  bus.rsp_rdata,      32'd0);
        chk_eq("wr_done",   32'(bus.busy),      32'd0);
        cyc(); #1;
        chk_eq("wr_pulse", 32'(bus.rsp_valid), 32'd0);

        // reads: byte and halfword masking, size 3 behaves as word
        single_read("rdb", 7'd68, 2'd0, 32'hFFFFFF05, 32'h00000005, 2'd0);
        single_read("rdh", 7'd70, 2'd1, 32'h12345678, 32'h00005678, 2'd1);
        single_read("rdw", 7'd76, 2'd3, 32'h9ABCDEF0, 32'h9ABCDEF0, 2'd2);

        // back-to-back writes 0,4,8 then read 72
        cyc(); drive_cmd(1'b1, 7'd0, 2'd2, 32'h00000100); #1;
        chk_eq("b2b_rdy0", 32'(bus.cmd_ready), 32'd1);
        cyc(); drive_cmd(1'b1, 7'd4, 2'd2, 32'h00000104); #1;
        chk_eq("b2b_rdy1", 32'(bus.cmd_ready), 32'd1);
        chk_eq("b2b_a0", 32'(bus.haddr), 32'd0);
        chk_eq("b2b_t0", 32'(bus.htrans), 32'd2);
        cyc(); drive_cmd(1'b1, 7'd8, 2'd2, 32'h00000108); #1;
        chk_eq("b2b_a1", 32'(bus.haddr), 32'd4);
        chk_eq("b2b_t1", 32'(bus.htrans), 32'd2);
        chk_eq("b2b_wd0", bus.hwdata, 32'h00000100);
        cyc(); drive_cmd(1'b0, 7'd72, 2'd2, 32'h0); #1;
        chk_eq("b2b_a2", 32'(bus.haddr), 32'd8);
        chk_eq("b2b_t2", 32'(bus.htrans), 32'd2);
        chk_eq("b2b_wd1", bus.hwdata, 32'h00000104);
        chk_eq("b2b_rv0", 32'(bus.rsp_valid), 32'd1);
        cyc(); drive_idle(); #1;
        chk_eq("b2b_a3", 32'(bus.haddr), 32'd72);
        chk_eq("b2b_t3", 32'(bus.htrans), 32'd2);
        chk_eq("b2b_w3", 32'(bus.hwrite), 32'd0);
        chk_eq("b2b_wd2", bus.hwdata, 32'h00000108);
        chk_eq("b2b_rv1", 32'(bus.rsp_valid), 32'd1);
        cyc(); slave(1'b1, 1'b0, 32'h11223344); #1;
        chk_eq("b2b_t4", 32'(bus.htrans), 32'd0);
        chk_eq("b2b_rv2", 32'(bus.rsp_valid), 32'd1);
        cyc(); slave(1'b1, 1'b0, 32'h0); #1;
        chk_eq("b2b_rv3", 32'(bus.rsp_valid), 32'd1);
        chk_eq("b2b_rd3", bus.rsp_rdata, 32'h11223344);
        cyc(); #1;
        chk_eq("b2b_end", 32'(bus.rsp_valid), 32'd0);

        // two-cycle ERROR on write 64 with read 68 queued behind it
        cyc(); drive_cmd(1'b1, 7'd64, 2'd2, 32'hCAFE0001); #1;
        cyc(); drive_cmd(1'b0, 7'd68, 2'd2, 32'h0); #1;
        chk_eq("err_a0", 32'(bus.haddr), 32'd64);
        chk_eq("err_rdy0", 32'(bus.cmd_ready), 32'd1);
        cyc(); drive_idle(); slave(1'b0, 1'b1, 32'h0); #1;
        chk_eq("err_e1_t", 32'(bus.htrans), 32'd2);
        chk_eq("err_e1_a", 32'(bus.haddr), 32'd68);
        chk_eq("err_e1_rdy", 32'(bus.cmd_ready), 32'd0);
        chk_eq("err_e1_wd", bus.hwdata, 32'hCAFE0001);
        cyc(); slave(1'b1, 1'b1, 32'h0); #1;
        chk_eq("err_e2_t", 32'(bus.htrans), 32'd0);
        chk_eq("err_e2_sel", 32'(bus.hsel), 32'd1);
        chk_eq("err_e2_a", 32'(bus.haddr), 32'd68);
        chk_eq("err_e2_rv", 32'(bus.rsp_valid), 32'd0);
        cyc(); slave(1'b1, 1'b0, 32'h0); #1;
        chk_eq("err_rv", 32'(bus.rsp_valid), 32'd1);
        chk_eq("err_re", 32'(bus.rsp_error), 32'd1);
        chk_eq("err_reissue_t", 32'(bus.htrans), 32'd2);
        chk_eq("err_reissue_a", 32'(bus.haddr), 32'd68);
        cyc(); slave(1'b1, 1'b0, 32'h0BADF00D); #1;
        chk_eq("err_gap_rv", 32'(bus.rsp_valid), 32'd0);
        chk_eq("err_gap_busy", 32'(bus.busy), 32'd1);
        cyc(); slave(1'b1, 1'b0, 32'h0); #1;
        chk_eq("err_rd_rv", 32'(bus.rsp_valid), 32'd1);
        chk_eq("err_rd_re", 32'(bus.rsp_error), 32'd0);
        chk_eq("err_rd_rd", bus.rsp_rdata, 32'h0BADF00D);

        // three wait states on read 36 with write 40 held in A
        cyc(); drive_cmd(1'b0, 7'd36, 2'd2, 32'h0); #1;
        cyc(); drive_cmd(1'b1, 7'd40, 2'd1, 32'h00000055); #1;
        chk_eq("ws_a0", 32'(bus.haddr), 32'd36);
        for (int i = 0; i < 3; i++) begin
            cyc(); drive_idle(); slave(1'b0, 1'b0, 32'h0); #1;
            chk_eq("ws_haddr",  32'(bus.haddr),     32'd40);
            chk_eq("ws_hsize",  32'(bus.hsize),     32'd1);
            chk_eq("ws_hwrite", 32'(bus.hwrite),    32'd1);
            chk_eq("ws_crdy",   32'(bus.cmd_ready), 32'd0);
            chk_eq("ws_rv",     32'(bus.rsp_valid), 32'd0);
        end
        cyc(); slave(1'b1, 1'b0, 32'h87654321); #1;
        chk_eq("ws_rel_crdy", 32'(bus.cmd_ready), 32'd1);
        chk_eq("ws_rel_t", 32'(bus.htrans), 32'd2);
        cyc(); slave(1'b1, 1'b0, 32'h0); #1;
        chk_eq("ws_rv1", 32'(bus.rsp_valid), 32'd1);
        chk_eq("ws_rd1", bus.rsp_rdata, 32'h87654321);
        chk_eq("ws_wd", bus.hwdata, 32'h00000055);
        cyc(); #1;
        chk_eq("ws_rv2", 32'(bus.rsp_valid), 32'd1);
        chk_eq("ws_rd2", bus.rsp_rdata, 32'd0);
        cyc(); #1;
        chk_eq("ws_rv3", 32'(bus.rsp_valid), 32'd0);

`ifdef AHB_MASTER_TIMEOUT_EN
        // watchdog: read 20 stalls for 16 cycles, write 24 in A is flushed
        cyc(); drive_cmd(1'b0, 7'd20, 2'd2, 32'h0); #1;
        cyc(); drive_cmd(1'b1, 7'd24, 2'd2, 32'h00000077); #1;
        for (int i = 0; i < 16; i++) begin
            cyc(); drive_idle(); slave(1'b0, 1'b0, 32'hFFFFFFFF); #1;
            chk_eq("tmo_wait_rv", 32'(bus.rsp_valid), 32'd0);
            chk_eq("tmo_wait_t",  32'(bus.htrans),    32'd2);
        end
        cyc(); #1;
        chk_eq("tmo_rv",   32'(bus.rsp_valid), 32'd1);
        chk_eq("tmo_re",   32'(bus.rsp_error), 32'd1);
        chk_eq("tmo_rd",   bus.rsp_rdata,      32'd0);
        chk_eq("tmo_t",    32'(bus.htrans),    32'd0);
        chk_eq("tmo_busy", 32'(bus.busy),      32'd0);
        cyc(); #1;
        chk_eq("tmo_fl_rv", 32'(bus.rsp_valid), 32'd1);
        chk_eq("tmo_fl_re", 32'(bus.rsp_error), 32'd1);
        chk_eq("tmo_fl_t",  32'(bus.htrans),    32'd0);
        cyc(); slave(1'b1, 1'b0, 32'h0); #1;
        chk_eq("tmo_end_rv", 32'(bus.rsp_valid), 32'd0);
`endif

        // reset asserted while a write sits in a wait state
        cyc(); drive_cmd(1'b1, 7'd12, 2'd2, 32'h0000ABCD); #1;
        cyc(); drive_idle(); #1;
        cyc(); slave(1'b0, 1'b0, 32'h0); #1;
        chk_eq("mrst_busy", 32'(bus.busy), 32'd1);
        cyc(); rst = 1'b1; #1;
        cyc(); rst = 1'b0; slave(1'b1, 1'b0, 32'h0); #1;
        chk_reset_outputs("mrst");
        cyc(); #1;
        chk_eq("mrst_norsp", 32'(bus.rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
